// File: rtl/temp_fan_pkg.sv
// temp_fan_pkg: shared fan-state encoding and sizing helpers for the temperature fan controller.
package temp_fan_pkg;

    localparam logic [1:0] FAN_STATE_OFF  = 2'd0;
    localparam logic [1:0] FAN_STATE_LOW  = 2'd1;
    localparam logic [1:0] FAN_STATE_HIGH = 2'd2;

    typedef enum logic [1:0] {
        FAN_OFF  = FAN_STATE_OFF,
        FAN_LOW  = FAN_STATE_LOW,
        FAN_HIGH = FAN_STATE_HIGH
    } fan_state_t;

    // Running sum needs the sample width plus one bit per doubling of the window.
    function automatic int sumWidth(input int avgLog2);
        return 8 + avgLog2;
    endfunction

endpackage

// File: rtl/temp_fan_ctrl_if.sv
// temp_fan_ctrl_if: temperature input and fan status outputs of temp_fan_ctrl.
interface temp_fan_ctrl_if;
    import temp_fan_pkg::*;

    logic signed [7:0] temperature;
    logic signed [7:0] tempAvg;
    logic              avgValid;
    fan_state_t        fanState;
    logic              fanPwm;
    logic              overTemp;

    modport master (
        output temperature,
        input  tempAvg, avgValid, fanState, fanPwm, overTemp
    );

    modport slave (
        input  temperature,
        output tempAvg, avgValid, fanState, fanPwm, overTemp
    );

endinterface

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: fan PWM with a duty that only changes on period boundaries.
// Optional macro FAN_KICKSTART_EN adds a full-drive kick requested on OFF->LOW.
module fan_pwm_gen
    import temp_fan_pkg::*;
#(
    parameter int PWM_PERIOD = 400,
    parameter int DUTY_LOW   = 160
`ifdef FAN_KICKSTART_EN
    , parameter int KICK_CYCLES = 5000000
`endif
) (
    input  logic       CLK_10MHZ,
    input  logic       RST_N,
    input  fan_state_t fanState,
`ifdef FAN_KICKSTART_EN
    input  logic       kickReq,
`endif
    output logic       fanPwm
);

    localparam int CW = $clog2(PWM_PERIOD + 1);

    logic [CW-1:0] pwmCnt;
    logic [CW-1:0] duty;
    logic [CW-1:0] activeDuty;
    logic          pwmWrap;
    logic          kickActive;

    always_comb begin
        activeDuty = CW'(PWM_PERIOD);
        case (fanState)
            FAN_OFF: activeDuty = '0;
            FAN_LOW: activeDuty = CW'(DUTY_LOW);
            default: activeDuty = CW'(PWM_PERIOD);
        endcase
    end

    assign pwmWrap = (pwmCnt == CW'(PWM_PERIOD - 1));

`ifdef FAN_KICKSTART_EN
    localparam int KW = $clog2(KICK_CYCLES + 1);
    logic [KW-1:0] kickCnt;

    // A request wins over cancellation, since fanState still shows OFF on the request cycle.
    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            kickCnt <= '0;
        end else if (kickReq) begin
            kickCnt <= KW'(KICK_CYCLES);
        end else if (fanState != FAN_LOW) begin
            kickCnt <= '0;
        end else if (kickCnt != '0) begin
            kickCnt <= kickCnt - KW'(1);
        end
    end

    assign kickActive = (kickCnt != '0);
`else
    assign kickActive = 1'b0;
`endif

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            pwmCnt <= '0;
            duty   <= CW'(PWM_PERIOD);
            fanPwm <= 1'b0;
        end else begin
            pwmCnt <= pwmWrap ? '0 : pwmCnt + CW'(1);
            if (pwmWrap) begin
                duty <= activeDuty;
            end
            fanPwm <= (pwmCnt < duty) || kickActive;
        end
    end

endmodule

// File: rtl/temp_fan_ctrl.sv
// temp_fan_ctrl: periodic sampling and window averaging of the 1-Wire temperature byte, hysteresis fan FSM,
// over-temperature flag and PWM fan drive. Optional macro FAN_KICKSTART_EN enables the OFF->LOW kick-start.
module temp_fan_ctrl
    import temp_fan_pkg::*;
#(
    parameter int SAMPLE_DIV = 10000000,
    parameter int AVG_LOG2   = 2,
    parameter int T_ON       = 40,
    parameter int T_HOT      = 55,
    parameter int T_CRIT     = 85,
    parameter int HYST       = 3,
    parameter int PWM_PERIOD = 400,
    parameter int DUTY_LOW   = 160
`ifdef FAN_KICKSTART_EN
    , parameter int KICK_CYCLES = 5000000
`endif
) (
    input  logic CLK_10MHZ,
    input  logic RST_N,
    temp_fan_ctrl_if.slave bus
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = sumWidth(AVG_LOG2);
    localparam int DIVW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FILLW = AVG_LOG2 + 1;

    localparam logic signed [7:0] TH_ON       = 8'(T_ON);
    localparam logic signed [7:0] TH_ON_OFF   = 8'(T_ON - HYST);
    localparam logic signed [7:0] TH_HOT      = 8'(T_HOT);
    localparam logic signed [7:0] TH_HOT_LOW  = 8'(T_HOT - HYST);
    localparam logic signed [7:0] TH_CRIT     = 8'(T_CRIT);
    localparam logic signed [7:0] TH_CRIT_CLR = 8'(T_CRIT - HYST);

    logic [DIVW-1:0]          divCnt;
    logic                     tick;
    logic signed [7:0]        tempSync1, tempSync2, tempStable;
    logic [DEPTH-1:0][7:0]    window;
    logic [AVG_LOG2-1:0]      wrPtr;
    logic [FILLW-1:0]         fillCnt;
    logic                     windowFull;
    logic signed [SW-1:0]     sum;
    logic                     avgUpdate, fsmUpdate;
    logic signed [7:0]        avgQ;
    logic                     avgValidQ;
    fan_state_t               stateQ, stateD;
    logic                     overTempQ, overTempD;
    logic                     fanPwmQ;

    assign tick       = (divCnt == DIVW'(SAMPLE_DIV - 1));
    assign windowFull = (fillCnt == FILLW'(DEPTH));

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            divCnt <= '0;
        end else begin
            divCnt <= tick ? '0 : divCnt + DIVW'(1);
        end
    end

    // The byte can change at any time; only a value seen unchanged on two consecutive clocks is taken.
    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            tempSync1  <= '0;
            tempSync2  <= '0;
            tempStable <= '0;
        end else begin
            tempSync1 <= bus.temperature;
            tempSync2 <= tempSync1;
            if (tempSync1 == tempSync2) begin
                tempStable <= tempSync2;
            end
        end
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            window    <= '0;
            wrPtr     <= '0;
            fillCnt   <= '0;
            sum       <= '0;
            avgUpdate <= 1'b0;
        end else begin
            avgUpdate <= tick;
            if (tick) begin
                window[wrPtr] <= tempStable;
                sum           <= sum + SW'(tempStable) - SW'($signed(window[wrPtr]));
                wrPtr         <= wrPtr + AVG_LOG2'(1);
                if (!windowFull) begin
                    fillCnt <= fillCnt + FILLW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            avgQ      <= '0;
            avgValidQ <= 1'b0;
            fsmUpdate <= 1'b0;
        end else begin
            fsmUpdate <= avgUpdate;
            if (avgUpdate && windowFull) begin
                avgQ      <= 8'(sum >>> AVG_LOG2);
                avgValidQ <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            stateQ    <= FAN_HIGH;
            overTempQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            overTempQ <= overTempD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        overTempD = overTempQ;
        if (fsmUpdate && avgValidQ) begin
            case (stateQ)
                FAN_OFF: begin
                    if (avgQ >= TH_HOT)     stateD = FAN_HIGH;
                    else if (avgQ >= TH_ON) stateD = FAN_LOW;
                end
                FAN_LOW: begin
                    if (avgQ >= TH_HOT)         stateD = FAN_HIGH;
                    else if (avgQ <= TH_ON_OFF) stateD = FAN_OFF;
                end
                default: begin
                    if (avgQ <= TH_ON_OFF)       stateD = FAN_OFF;
                    else if (avgQ <= TH_HOT_LOW) stateD = FAN_LOW;
                end
            endcase
            if (avgQ >= TH_CRIT)          overTempD = 1'b1;
            else if (avgQ <= TH_CRIT_CLR) overTempD = 1'b0;
        end
    end

`ifdef FAN_KICKSTART_EN
    logic kickReq;
    assign kickReq = (stateQ == FAN_OFF) && (stateD == FAN_LOW);
`endif

    fan_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_LOW   (DUTY_LOW)
`ifdef FAN_KICKSTART_EN
        , .KICK_CYCLES (KICK_CYCLES)
`endif
    ) pwmGen (
        .CLK_10MHZ (CLK_10MHZ),
        .RST_N     (RST_N),
        .fanState  (stateQ),
`ifdef FAN_KICKSTART_EN
        .kickReq   (kickReq),
`endif
        .fanPwm    (fanPwmQ)
    );

    assign bus.tempAvg  = avgQ;
    assign bus.avgValid = avgValidQ;
    assign bus.fanState = stateQ;
    assign bus.fanPwm   = fanPwmQ;
    assign bus.overTemp = overTempQ;

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// tb_temp_fan_ctrl: directed and random temperature sequences checked against a window-average/hysteresis model.
module tb_temp_fan_ctrl;

    localparam int SAMPLE_DIV = 10;
    localparam int PWM_PERIOD = 10;
    localparam int DUTY_LOW   = 4;
    localparam int AVG_LOG2   = 2;
    localparam int DEPTH      = 1 << AVG_LOG2;

    logic CLK_10MHZ = 1'b0;
    logic RST_N     = 1'b0;

    temp_fan_ctrl_if bus();

    temp_fan_ctrl #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .AVG_LOG2   (AVG_LOG2),
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_LOW   (DUTY_LOW)
    ) dut (
        .CLK_10MHZ (CLK_10MHZ),
        .RST_N     (RST_N),
        .bus       (bus)
    );

    always #50 CLK_10MHZ = ~CLK_10MHZ;

    int compareCnt  = 0;
    int mismatchCnt = 0;

    // Reference model: last DEPTH samples, floor average, fan state 0/1/2, over-temperature flag.
    int sampleQ[$];
    int mAvg, mValid, mState, mStatePrev, mOver;

    function automatic int floorAvg(input int s);
        if (s >= 0) return s / DEPTH;
        return -((-s + DEPTH - 1) / DEPTH);
    endfunction

    function automatic int dutyOf(input int st);
        if (st == 0) return 0;
        if (st == 1) return DUTY_LOW;
        return PWM_PERIOD;
    endfunction

    task automatic modelReset();
        sampleQ.delete();
        mAvg = 0; mValid = 0; mState = 2; mStatePrev = 2; mOver = 0;
    endtask

    task automatic modelTick(input int t);
        int s;
        sampleQ.push_back(t);
        if (sampleQ.size() > DEPTH) void'(sampleQ.pop_front());
        if (sampleQ.size() == DEPTH) begin
            s = 0;
            foreach (sampleQ[i]) s += sampleQ[i];
            mAvg = floorAvg(s);
            mValid = 1;
            if (mState == 0) begin
                if (mAvg >= 55) mState = 2;
                else if (mAvg >= 40) mState = 1;
            end else if (mState == 1) begin
                if (mAvg >= 55) mState = 2;
                else if (mAvg <= 37) mState = 0;
            end else begin
                if (mAvg <= 37) mState = 0;
                else if (mAvg <= 52) mState = 1;
            end
            if (mAvg >= 85) mOver = 1;
            else if (mAvg <= 82) mOver = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
        compareCnt++;
        assert (obs === exp) else begin
            mismatchCnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic doReset(input int holdCycles);
        RST_N = 1'b0;
        repeat (holdCycles) @(negedge CLK_10MHZ);
        modelReset();
        checkOutput("rstTempAvg", bus.tempAvg, 0);
        checkOutput("rstAvgValid", bus.avgValid, 0);
        checkOutput("rstFanState", bus.fanState, 2);
        checkOutput("rstFanPwm", bus.fanPwm, 0);
        checkOutput("rstOverTemp", bus.overTemp, 0);
        RST_N = 1'b1;
        @(negedge CLK_10MHZ);
        checkOutput("pwmAfterRelease", bus.fanPwm, 1);
        @(negedge CLK_10MHZ);
    endtask

    // One sample period: the value is applied well before the tick, results checked after the FSM slot.
    task automatic applyStimulus(input int t);
        int highs;
        int entryState;
        bit steady;
        highs      = 0;
        entryState = mState;
        steady     = (mStatePrev == mState);
        bus.temperature = 8'(t);
        repeat (SAMPLE_DIV) begin
            @(negedge CLK_10MHZ);
            highs += int'(bus.fanPwm);
        end
        mStatePrev = mState;
        modelTick(t);
        checkOutput("tempAvg", bus.tempAvg, 16'(mAvg));
        checkOutput("avgValid", bus.avgValid, 16'(mValid));
        checkOutput("fanState", bus.fanState, 16'(mState));
        checkOutput("overTemp", bus.overTemp, 16'(mOver));
        if (steady) checkOutput("pwmHighCount", 16'(highs), 16'(dutyOf(entryState)));
    endtask

    initial begin
        bus.temperature = '0;
        $display("[TB] temp_fan_ctrl bench start");
        doReset(3);

        repeat (4) applyStimulus(25);
        checkOutput("planAvg25", bus.tempAvg, 25);
        repeat (3) applyStimulus(45);
        checkOutput("planLowAt40", bus.fanState, 1);
        applyStimulus(17);
        applyStimulus(41);
        checkOutput("planOffAt37", bus.fanState, 0);

        repeat (4) applyStimulus(-10);
        checkOutput("planAvgNeg10", bus.tempAvg, -10);
        applyStimulus(-1);
        applyStimulus(-1);
        applyStimulus(-1);
        applyStimulus(0);
        checkOutput("planAvgFloorNeg", bus.tempAvg, -1);

        repeat (5) applyStimulus(90);
        checkOutput("planOverSet", bus.overTemp, 1);
        repeat (4) applyStimulus(82);
        checkOutput("planOverClear", bus.overTemp, 0);

        repeat (30) applyStimulus(int'($urandom_range(140)) - 20);

        repeat (4) applyStimulus(45);
        checkOutput("preResetLow", bus.fanState, 1);
        doReset(1);
        repeat (3) applyStimulus(60);
        repeat (3) applyStimulus(int'($urandom_range(100)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule
